pll_lock_supervisor: RTL

- Consumes the raw lock indication of a PLL (the PLL_MOD `lock` output) and drives that PLL's reset input.
- Debounces lock, runs reset/timeout/retry sequencing, and produces a clean synchronous reset for logic downstream of the PLL.
- Runs on the free-running init clock, never on the PLL output clock.
- Monitors continuously after lock and re-sequences the PLL on lock loss.

---
 rtl/pll_lock_supervisor.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes and debounces the PLL lock indication,
// sequences the PLL reset with timeout/retry, and provides a clean reset
// for logic downstream of the PLL. Runs entirely on the free-running init clock.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 20,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 7,
  parameter int CNT_W               = 16
) (
  input  logic       init_clk,
  input  logic       reset,
  input  logic       pll_lock_raw,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       locked,
  output logic       lock_lost,
  output logic [3:0] retry_count,
  output logic       fail
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABILIZE,
    S_LOCKED,
    S_FAILED
  } state_t;

  // Terminal counts: the counter starts at 0 on state entry, so N cycles end at N-1.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_LAST = 4'(MAX_RETRIES - 1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pll_rst;
  logic                   r_sys_rst;
  logic                   r_locked;
  logic                   r_lock_lost;
  logic                   r_fail;
  logic [3:0]             r_retry;

  logic                   w_lock_s;
  state_t                 w_state_nxt;
  logic [3:0]             w_retry_nxt;
  logic                   w_lock_lost_nxt;
  logic                   w_restart;

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Bring the asynchronous PLL lock into the init clock domain.
  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock_raw};
    end
  end

  // Next-state, retry and lock-loss decisions; force_relock overrides everything.
  always_comb begin
    w_state_nxt     = r_state;
    w_retry_nxt     = r_retry;
    w_lock_lost_nxt = 1'b0;
    w_restart       = 1'b0;
    if (force_relock) begin
      w_state_nxt = S_RESET_PLL;
      w_retry_nxt = 4'd0;
      w_restart   = 1'b1;
    end else begin
      case (r_state)
        S_RESET_PLL: begin
          if (r_cnt == RST_LAST) w_state_nxt = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          // A lock arriving on the timeout cycle still counts as a lock.
          if (w_lock_s) begin
            w_state_nxt = S_STABILIZE;
          end else if (r_cnt == TMO_LAST) begin
            if (r_retry == RETRY_LAST) begin
              w_state_nxt = S_FAILED;
              w_retry_nxt = RETRY_MAX;
            end else begin
              w_state_nxt = S_RESET_PLL;
              w_retry_nxt = r_retry + 4'd1;
            end
          end
        end
        S_STABILIZE: begin
          // Any drop, even on the terminal cycle, restarts the wait.
          if (!w_lock_s) begin
            w_state_nxt = S_WAIT_LOCK;
          end else if (r_cnt == STAB_LAST) begin
            w_state_nxt = S_LOCKED;
            w_retry_nxt = 4'd0;
          end
        end
        S_LOCKED: begin
          w_retry_nxt = 4'd0;
          if (!w_lock_s) begin
            w_state_nxt     = S_RESET_PLL;
            w_lock_lost_nxt = 1'b1;
          end
        end
        S_FAILED: begin
          w_state_nxt = S_FAILED;
        end
        default: begin
          w_state_nxt = S_RESET_PLL;
          w_retry_nxt = 4'd0;
        end
      endcase
    end
  end

  // State, saturating cycle counter and outputs registered from the next state.
  always_ff @(posedge init_clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_RESET_PLL;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_sys_rst   <= 1'b1;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
      r_fail      <= 1'b0;
      r_retry     <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_restart || (w_state_nxt != r_state)) begin
        r_cnt <= '0;
      end else if (r_cnt != {CNT_W{1'b1}}) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_pll_rst   <= (w_state_nxt == S_RESET_PLL);
      r_sys_rst   <= (w_state_nxt != S_LOCKED);
      r_locked    <= (w_state_nxt == S_LOCKED);
      r_lock_lost <= w_lock_lost_nxt;
      r_fail      <= (w_state_nxt == S_FAILED);
      r_retry     <= w_retry_nxt;
    end
  end

  assign pll_rst     = r_pll_rst;
  assign sys_rst     = r_sys_rst;
  assign locked      = r_locked;
  assign lock_lost   = r_lock_lost;
  assign fail        = r_fail;
  assign retry_count = r_retry;

endmodule
